// File: rtl/adder_controller.sv
// adder_controller: multi-cycle fetch/decode/execute sequencer for the four-instruction adding-machine CPU
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   op_code[1:0]        IR[7:6]: 00 LDA, 01 STA, 10 JMP, 11 ADD
//   mem_rdy             memory completes the current read/write this cycle
//   ir_on_adr/pc_on_adr address-bus source select
//   ld_ir/ld_ac/ld_pc   register load strobes
//   inc_pc/clr_pc       PC increment / clear
//   pass_add            ALU select (1 add, 0 pass)
//   rd_mem/wr_mem       memory read / write request
//   bus_err             sticky wait-state timeout flag
//   step/halted         single-step control, present only with SINGLE_STEP_EN defined
module adder_controller #(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] op_code,
    input  logic       mem_rdy,
`ifdef SINGLE_STEP_EN
    input  logic       step,
    output logic       halted,
`endif
    output logic       ir_on_adr,
    output logic       pc_on_adr,
    output logic       ld_ir,
    output logic       ld_ac,
    output logic       ld_pc,
    output logic       inc_pc,
    output logic       clr_pc,
    output logic       pass_add,
    output logic       rd_mem,
    output logic       wr_mem,
    output logic       bus_err
);
    typedef enum logic [3:0] {IDLE, CLR, FETCH, DECODE, LDA, STA, JMP, ADD, ERR, HOLD} state_t;
`ifdef SINGLE_STEP_EN
    localparam state_t NXT = HOLD;
`else
    localparam state_t NXT = FETCH;
`endif
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic bus_err_q, bus_err_d;
    logic stall;
    assign stall = (state_q inside {FETCH, LDA, STA, ADD}) && !mem_rdy;
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        bus_err_d = bus_err_q;
        case (state_q)
            IDLE:        state_d = CLR;
            CLR:         state_d = NXT;
            FETCH:       state_d = mem_rdy ? DECODE : FETCH;
            // unknown op codes fall to the default arm and execute as JMP
            DECODE: case (op_code)
                2'b00:   state_d = LDA;
                2'b01:   state_d = STA;
                2'b11:   state_d = ADD;
                default: state_d = JMP;
            endcase
            LDA, STA, ADD: state_d = mem_rdy ? NXT : state_q;
            JMP:         state_d = NXT;
            ERR:         state_d = ERR;
`ifdef SINGLE_STEP_EN
            HOLD:        state_d = step ? FETCH : HOLD;
`endif
            default:     state_d = IDLE;
        endcase
        // a completing cycle never reaches this branch, so mem_rdy at the limit wins
        if (stall) begin
            if (cnt_q == CNT_W'(WAIT_LIMIT)) begin
                state_d   = ERR;
                bus_err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end
    assign pc_on_adr = state_q == FETCH;
    assign ir_on_adr = state_q inside {DECODE, LDA, STA, ADD};
    assign ld_ir     = (state_q == FETCH) && mem_rdy;
    assign inc_pc    = (state_q == FETCH) && mem_rdy;
    assign ld_ac     = (state_q inside {LDA, ADD}) && mem_rdy;
    assign ld_pc     = state_q == JMP;
    assign clr_pc    = state_q == CLR;
    assign pass_add  = state_q == ADD;
    assign rd_mem    = state_q inside {FETCH, LDA, ADD};
    assign wr_mem    = state_q == STA;
    assign bus_err   = bus_err_q;
`ifdef SINGLE_STEP_EN
    assign halted    = state_q == HOLD;
`endif
endmodule

// File: tb/tb_adder_controller.sv
// tb_adder_controller: scoreboard bench driving instruction-level random traffic into adder_controller
module tb_adder_controller;
    localparam int WL = 15;
    localparam logic [10:0] IR = 11'd1 << 10, PC = 11'd1 << 9, LIR = 11'd1 << 8, LAC = 11'd1 << 7,
                            LPC = 11'd1 << 6, INC = 11'd1 << 5, CLRP = 11'd1 << 4, ADDS = 11'd1 << 3,
                            RD = 11'd1 << 2, WR = 11'd1 << 1, BE = 11'd1;
    logic clk = 0, reset = 1, mem_rdy = 0;
    logic [1:0] op_code = 0;
    logic ir_on_adr, pc_on_adr, ld_ir, ld_ac, ld_pc, inc_pc, clr_pc, pass_add, rd_mem, wr_mem, bus_err;
    logic [10:0] q[$];
    int checks = 0, errors = 0;

    adder_controller #(.WAIT_LIMIT(WL), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .op_code(op_code), .mem_rdy(mem_rdy),
        .ir_on_adr(ir_on_adr), .pc_on_adr(pc_on_adr), .ld_ir(ld_ir), .ld_ac(ld_ac),
        .ld_pc(ld_pc), .inc_pc(inc_pc), .clr_pc(clr_pc), .pass_add(pass_add),
        .rd_mem(rd_mem), .wr_mem(wr_mem), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        logic [10:0] got, e;
        if (q.size() != 0) begin
            e = q.pop_front();
            got = {ir_on_adr, pc_on_adr, ld_ir, ld_ac, ld_pc, inc_pc, clr_pc, pass_add, rd_mem, wr_mem, bus_err};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL strobes t=%0t got %b required %b (ir pc ldir ldac ldpc inc clr add rd wr err)",
                         $time, got, e);
            end
        end
    end

    function automatic logic [1:0] rop();
        return 2'($urandom_range(0, 3));
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // k: 0 fetch, 1 LDA, 2 STA, 3 ADD
    function automatic logic [10:0] mem_vec(input int k, input logic r);
        case (k)
            0:       return PC | RD | (r ? (LIR | INC) : 11'd0);
            1:       return IR | RD | (r ? LAC : 11'd0);
            2:       return IR | WR;
            default: return IR | RD | ADDS | (r ? LAC : 11'd0);
        endcase
    endfunction

    task automatic cyc(input logic rs, input logic r, input logic [1:0] op, input logic [10:0] e);
        @(posedge clk);
        #1;
        reset = rs;
        mem_rdy = r;
        op_code = op;
        q.push_back(e);
    endtask

    task automatic do_reset();
        cyc(1, rbit(), rop(), 11'd0);
        cyc(1, rbit(), rop(), 11'd0);
        cyc(0, rbit(), rop(), 11'd0);
        cyc(0, rbit(), rop(), CLRP);
    endtask

    // n stalled cycles then completion; the stall after WL earlier stalls times out
    task automatic mem_phase(input int k, input int n, output bit erred);
        erred = 0;
        for (int i = 0; i < n; i++) begin
            cyc(0, 0, rop(), mem_vec(k, 0));
            if (i == WL) begin
                erred = 1;
                return;
            end
        end
        cyc(0, 1, rop(), mem_vec(k, 1));
    endtask

    task automatic instr(input logic [1:0] op, input int fs, input int es, output bit erred);
        mem_phase(0, fs, erred);
        if (erred) return;
        cyc(0, rbit(), op, IR);
        if (op == 2'b10) cyc(0, rbit(), rop(), LPC);
        else mem_phase(op == 2'b00 ? 1 : op == 2'b01 ? 2 : 3, es, erred);
    endtask

    task automatic err_tail();
        for (int i = 0; i < 4; i++) cyc(0, i > 1 ? 1'b1 : rbit(), rop(), BE);
        do_reset();
    endtask

    function automatic int rstall();
        return $urandom_range(0, 9) == 0 ? int'($urandom_range(0, 17)) : int'($urandom_range(0, 2));
    endfunction

    initial begin
        bit e;
        do_reset();
        instr(2'b00, 0, 0, e);
        instr(2'b11, 0, 0, e);
        instr(2'b01, 0, 3, e);
        instr(2'b10, 0, 0, e);
        instr(2'b00, 15, 0, e);
        instr(2'b11, 0, 15, e);
        instr(2'b00, 16, 0, e);
        err_tail();
        instr(2'b01, 0, 20, e);
        err_tail();
        cyc(0, 1, rop(), mem_vec(0, 1));
        cyc(0, rbit(), 2'b00, IR);
        cyc(1, 1, rop(), 11'd0);
        cyc(1, 1, rop(), 11'd0);
        cyc(0, 1, rop(), 11'd0);
        cyc(0, 1, rop(), CLRP);
        for (int n = 0; n < 200; n++) begin
            instr(rop(), rstall(), rstall(), e);
            if (e) err_tail();
        end
        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain got %0d pending required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got running required finished");
        $fatal(1);
    end
endmodule
